uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive end of the processor's UART link: 8N1, LSB first, fixed clocks-per-bit, matching the transmitter's line format. Recovers bytes from the asynchronous `rxd` pin and presents each one on an AXI-Stream-style valid/ready output. Also reports framing and overrun errors and keeps a count of good bytes. Sits between the board RX pin and the processor's instruction/data loader.

## Interface
- `CLKS_PER_BIT`, 64: clock cycles per bit. Must be even and in the range 8..256.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rxd` in 1: asynchronous serial input; idles high.
- `output_axis_tdata` out 8: received byte.
- `output_axis_tvalid` out 1: byte available.
- `output_axis_tready` in 1: consumer accepts the byte.
- `busy` out 1: a frame is being received, i.e. state is not IDLE.
- `frame_error` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_error` out 1: one-cycle pulse when a good byte is dropped because the output is still occupied.
- `counter` out 16: count of good bytes loaded to the output; wraps at 0xFFFF→0.

## Operation
- Synchroniser: two flops `s1`→`s2`, plus `prev` (last `s2`). All three reset to 0, so a line held low through reset never looks like a start bit.
- Falling edge: `prev`=1 and `s2`=0.
- States: IDLE, START, DATA, STOP, WAIT_IDLE. The bit timer is a down-counter of width $clog2(CLKS_PER_BIT); the bit index runs 0..7.
- IDLE: on a falling edge, go to START and load timer = CLKS_PER_BIT/2−1.
- START: decrement the timer. When it is 0, sample `s2`:
  - 0 → DATA, timer = CLKS_PER_BIT−1, index = 0.
  - 1 → treat as a glitch and return to IDLE. No error is flagged.
- DATA: when the timer is 0, shift `s2` into the MSB of the shift register (shift right) and reload the timer.
  - After the sample at index 7, go to STOP. Otherwise increment the index.
- STOP: when the timer is 0, sample `s2`.
  - 1 → good byte, return to IDLE.
  - 0 → pulse `frame_error`, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until `s2`=1, then go to IDLE. A break condition therefore produces exactly one `frame_error`.
- Output register on a good byte:
  - Output empty, or `tvalid`&&`tready` in the same cycle: load `tdata`, set `tvalid`=1, increment `counter`.
  - Otherwise: pulse `overrun_error`. The old `tdata` and `counter` are unchanged.
- Handshake: a transfer happens in any cycle where `tvalid`&&`tready`. After the transfer `tvalid` drops, unless a new byte loads on the same edge.
- `tdata` is stable while `tvalid`=1.
- Reset values, applied on any cycle including mid-frame:
  - state = IDLE; timer, index and shift register = 0.
  - `tvalid`, `tdata`, `counter`, `busy`, `frame_error`, `overrun_error` = 0.

## Timing
- Let T0 be the first clock edge at which `rxd` is sampled low.
- `s2` is low after edge T0+1. The FSM enters START at edge T0+2, and `busy` rises after T0+2.
- Start-bit sample at T0+2+CLKS_PER_BIT/2.
- Data bit k (k=0..7) is sampled at T0+2+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
- Stop-bit sample at T0+2+CLKS_PER_BIT/2+9·CLKS_PER_BIT. With the default of 64 this is edge T0+610.
- `tvalid`, `counter`, `frame_error` and `overrun_error` update on that same edge. `busy` falls on that edge.
- A new start bit is accepted from the cycle after the return to IDLE. There is no minimum idle requirement beyond the synchroniser seeing `prev`=1. The tolerated stop-bit length is therefore ≥ CLKS_PER_BIT/2+2 cycles.
- The error pulses are exactly one cycle wide.

## Structure
- Shared package `uart_pkg`: `UART_DATA_BITS`=8, `UART_CLKS_PER_BIT_DEFAULT`=64, and the rx state enum (IDLE, START, DATA, STOP, WAIT_IDLE). The transmitter uses the same constants.
- One sub-module, `uart_rx_sync`: the two-flop synchroniser with `prev` and the falling-edge output, with synchronous reset to 0.
- FSM, timer and output register live in `uart_rx`.

## Test plan
- Byte 0xA5 sent by a bench transmitter with `tready` held at 1 → `tdata`=0xA5, `tvalid` high for one cycle at T0+610, `counter`=1, no errors.
- Bytes 0x3C then 0xC3 sent back-to-back with `tready`=0 → first byte held as 0x3C; at the second stop sample `overrun_error` pulses once; `counter`=1. Raise `tready` → 0x3C is transferred and `tvalid` drops.
- Byte sent with the stop bit forced low, then the line held low for 2000 cycles → exactly one `frame_error`, `tvalid` stays 0. Release the line, send 0x55 → 0x55 is received correctly.
- Low glitch on `rxd` of 10 cycles → `busy` pulses, then returns to IDLE with no output and no error.
- `rst` asserted at data bit 4 of a frame → all outputs 0 on the next cycle. The rest of the frame produces no byte; the next full frame 0x81 is received correctly.
- `rxd` held low through and after reset → no start is detected. After 64 cycles high, 0xFF is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receiver and transmitter.
// Both ends of the link use the same frame format and bit timing.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 64;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd pin, with a falling-edge detector.
// All flops reset to 0, so a line held low through reset never produces a falling edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_sync,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= rxd;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rxd_sync = s2;
  assign fall     = prev & ~s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, fixed clocks-per-bit, with a one-deep valid/ready
// output register, framing/overrun error pulses and a count of good bytes.
//
// Output handshake: a byte transfers on every rising edge where
// output_axis_tvalid && output_axis_tready; tdata is held stable while tvalid is high,
// and tvalid drops after the transfer unless a new byte loads on the same edge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] output_axis_tdata,
  output logic                      output_axis_tvalid,
  input  logic                      output_axis_tready,
  output logic                      busy,
  output logic                      frame_error,
  output logic                      overrun_error,
  output logic [15:0]               counter,
  output rx_state_t                 state_dbg
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);

  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

  logic rxd_sync;
  logic fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rxd_sync (rxd_sync),
    .fall     (fall)
  );

  rx_state_t                 state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [IW-1:0]             index_q, index_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      good_byte;
  logic                      frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      timer_q <= '0;
      index_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      index_q <= index_d;
      shift_q <= shift_d;
    end
  end

  // Every sample point is where the down-counting bit timer reaches zero.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    index_d     = index_q;
    shift_d     = shift_q;
    good_byte   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          timer_d = HALF_LOAD;
        end
      end
      RX_START: begin
        if (timer_q == '0) begin
          if (!rxd_sync) begin
            state_d = RX_DATA;
            timer_d = FULL_LOAD;
            index_d = '0;
          end else begin
            // Line came back high by mid start bit: a glitch, not a frame.
            state_d = RX_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RX_DATA: begin
        if (timer_q == '0) begin
          shift_d = {rxd_sync, shift_q[UART_DATA_BITS-1:1]};
          timer_d = FULL_LOAD;
          if (index_q == IDX_LAST) begin
            state_d = RX_STOP;
          end else begin
            index_d = index_q + IW'(1);
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RX_STOP: begin
        if (timer_q == '0) begin
          if (rxd_sync) begin
            good_byte = 1'b1;
            state_d   = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RX_WAIT_IDLE: begin
        // Hold here through a break so it raises only one frame_error.
        if (rxd_sync) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      output_axis_tdata  <= '0;
      output_axis_tvalid <= 1'b0;
      counter            <= '0;
      frame_error        <= 1'b0;
      overrun_error      <= 1'b0;
    end else begin
      frame_error   <= frame_err_d;
      overrun_error <= 1'b0;
      if (good_byte) begin
        if (!output_axis_tvalid || output_axis_tready) begin
          output_axis_tdata  <= shift_q;
          output_axis_tvalid <= 1'b1;
          counter            <= counter + 16'd1;
        end else begin
          overrun_error <= 1'b1;
        end
      end else if (output_axis_tvalid && output_axis_tready) begin
        output_axis_tvalid <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != RX_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a bit-level line driver, an expected-byte queue for the
// output stream, and error-pulse counters checked against hand-computed outcomes.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        busy;
  logic        frame_error;
  logic        overrun_error;
  logic [15:0] counter;
  rx_state_t   state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int fe_snap;
  int ov_snap;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk                (clk),
    .rst                (rst),
    .rxd                (rxd),
    .output_axis_tdata  (tdata),
    .output_axis_tvalid (tvalid),
    .output_axis_tready (tready),
    .busy               (busy),
    .frame_error        (frame_error),
    .overrun_error      (overrun_error),
    .counter            (counter),
    .state_dbg          (state_dbg)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- check task ----
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- error pulse counters ----
  always @(posedge clk) begin
    if (frame_error)   fe_cnt <= fe_cnt + 1;
    if (overrun_error) ov_cnt <= ov_cnt + 1;
  end

  // ---- scoreboard: every transfer must match the next expected byte ----
  always @(negedge clk) begin
    #1;
    if (!rst && tvalid && tready) begin
      check_eq("sb_expected_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_eq("sb_data", 32'(tdata), 32'(exp_q.pop_front()));
    end
  end

  // ---- line driver: start bit, 8 data bits LSB first, stop bit ----
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) rxd = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rxd = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rxd = stop_bit;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic snap_errs();
    fe_snap = fe_cnt;
    ov_snap = ov_cnt;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_busy;

    // ---- reset state ----
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check_eq("rst_tvalid",  32'(tvalid), 32'd0);
    check_eq("rst_tdata",   32'(tdata), 32'd0);
    check_eq("rst_counter", 32'(counter), 32'd0);
    check_eq("rst_busy",    32'(busy), 32'd0);
    check_eq("rst_errors",  32'({frame_error, overrun_error}), 32'd0);
    repeat (10) @(negedge clk);

    // ---- single byte 0xA5 with cycle-exact latency ----
    tready = 1'b1;
    snap_errs();
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (3) @(negedge clk); #1;
        check_eq("a5_busy_before_start", 32'(busy), 32'd0);
        @(negedge clk); #1;
        check_eq("a5_busy_in_start", 32'(busy), 32'd1);
        repeat (607) @(negedge clk); #1;
        check_eq("a5_tvalid_before_stop", 32'(tvalid), 32'd0);
        check_eq("a5_busy_before_stop", 32'(busy), 32'd1);
        @(negedge clk); #1;
        check_eq("a5_tvalid_at_stop", 32'(tvalid), 32'd1);
        check_eq("a5_tdata", 32'(tdata), 32'hA5);
        check_eq("a5_counter", 32'(counter), 32'd1);
        check_eq("a5_busy_after_stop", 32'(busy), 32'd0);
        @(negedge clk); #1;
        check_eq("a5_tvalid_after_xfer", 32'(tvalid), 32'd0);
      end
    join
    check_eq("a5_no_errors", 32'((fe_cnt - fe_snap) + (ov_cnt - ov_snap)), 32'd0);

    // ---- overrun: 0x3C then 0xC3 back-to-back with tready low ----
    @(negedge clk) tready = 1'b0;
    snap_errs();
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    #1;
    check_eq("ovr_tvalid", 32'(tvalid), 32'd1);
    check_eq("ovr_tdata_held", 32'(tdata), 32'h3C);
    check_eq("ovr_counter", 32'(counter), 32'd2);
    check_eq("ovr_pulses", 32'(ov_cnt - ov_snap), 32'd1);
    check_eq("ovr_no_frame_err", 32'(fe_cnt - fe_snap), 32'd0);
    @(negedge clk) tready = 1'b1;
    @(negedge clk); #1;
    check_eq("ovr_tvalid_drops", 32'(tvalid), 32'd0);

    // ---- framing error followed by a 2000-cycle break ----
    snap_errs();
    send_byte(8'h96, 1'b0);
    repeat (2000) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk); #1;
    check_eq("brk_one_frame_err", 32'(fe_cnt - fe_snap), 32'd1);
    check_eq("brk_tvalid", 32'(tvalid), 32'd0);
    check_eq("brk_counter", 32'(counter), 32'd2);
    check_eq("brk_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    repeat (10) @(negedge clk); #1;
    check_eq("brk_recover_counter", 32'(counter), 32'd3);
    check_eq("brk_recover_tdata", 32'(tdata), 32'h55);

    // ---- 10-cycle glitch ----
    snap_errs();
    fork
      begin
        @(negedge clk) rxd = 1'b0;
        repeat (10) @(negedge clk);
        rxd = 1'b1;
      end
      begin
        repeat (4) @(negedge clk); #1;
        check_eq("gl_busy_rise", 32'(busy), 32'd1);
        repeat (31) @(negedge clk); #1;
        check_eq("gl_busy_before_sample", 32'(busy), 32'd1);
        @(negedge clk); #1;
        check_eq("gl_busy_fall", 32'(busy), 32'd0);
      end
    join
    repeat (100) @(negedge clk); #1;
    check_eq("gl_tvalid", 32'(tvalid), 32'd0);
    check_eq("gl_counter", 32'(counter), 32'd3);
    check_eq("gl_no_errors", 32'((fe_cnt - fe_snap) + (ov_cnt - ov_snap)), 32'd0);

    // ---- reset in the middle of data bit 4 ----
    @(negedge clk) tready = 1'b0;
    send_byte(8'h5A, 1'b1);
    #1;
    check_eq("mrst_pending_valid", 32'(tvalid), 32'd1);
    check_eq("mrst_pending_counter", 32'(counter), 32'd4);
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (351) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check_eq("mrst_busy_in_data", 32'(state_dbg == RX_IDLE), 32'd1);
        check_eq("mrst_tvalid", 32'(tvalid), 32'd0);
        check_eq("mrst_tdata", 32'(tdata), 32'd0);
        check_eq("mrst_counter", 32'(counter), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_errors", 32'({frame_error, overrun_error}), 32'd0);
        rst = 1'b0;
      end
    join
    repeat (100) @(negedge clk); #1;
    check_eq("mrst_no_byte", 32'(tvalid), 32'd0);
    check_eq("mrst_idle", 32'(busy), 32'd0);
    tready = 1'b1;
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    repeat (10) @(negedge clk); #1;
    check_eq("mrst_next_counter", 32'(counter), 32'd1);
    check_eq("mrst_next_tdata", 32'(tdata), 32'h81);

    // ---- line held low through and after reset ----
    @(negedge clk) begin
      rxd = 1'b0;
      rst = 1'b1;
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (busy) seen_busy = 1'b1;
    end
    check_eq("low_rst_no_start", 32'(seen_busy), 32'd0);
    rxd = 1'b1;
    repeat (64) @(negedge clk);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1);
    repeat (10) @(negedge clk); #1;
    check_eq("low_rst_counter", 32'(counter), 32'd1);
    check_eq("low_rst_tdata", 32'(tdata), 32'hFF);

    // ---- report ----
    repeat (5) @(negedge clk); #1;
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
